sipo_shift_register: RTL and testbench

//  Serial-in/parallel-out shift register. Captures one bit from shift_in on every clk rising edge
//  and presents the last WIDTH bits in parallel. Sits behind a serial receiver/deserializer.
//  A bit counter flags each completed WIDTH-bit word.

---
 rtl/sipo_shift_register_if.sv | 45 ++++
 rtl/sipo_shift_register.sv | 72 +++++++
 tb/tb_sipo_shift_register.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sipo_shift_register_if.sv
// Serial-in / parallel-out bundle: serial bit in, window, word count and word strobe out.
// parity_out exists only when SIPO_PARITY_EN is defined.
interface sipo_shift_register_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             shift_in;
  logic [WIDTH-1:0] parallel_out;
  logic [CW-1:0]    bit_count;
  logic             word_valid;
`ifdef SIPO_PARITY_EN
  logic             parity_out;

  modport master (
    output shift_in,
    input  parallel_out,
    input  bit_count,
    input  word_valid,
    input  parity_out
  );

  modport slave (
    input  shift_in,
    output parallel_out,
    output bit_count,
    output word_valid,
    output parity_out
  );
`else
  modport master (
    output shift_in,
    input  parallel_out,
    input  bit_count,
    input  word_valid
  );

  modport slave (
    input  shift_in,
    output parallel_out,
    output bit_count,
    output word_valid
  );
`endif
endinterface

// File: rtl/sipo_shift_register.sv
// Serial-in/parallel-out shift register with word counter; SIPO_PARITY_EN adds parity_out.
// Latency: bit sampled at edge N is visible in parallel_out right after edge N.
// Backpressure: none, a bit is consumed on every non-reset edge.
module sipo_shift_register #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  sipo_shift_register_if.slave  sif
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] parallel_q, parallel_d, shifted;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic             word_valid_q, word_valid_d;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {parallel_q[WIDTH-2:0], sif.shift_in};
    end else begin : g_lsb_first
      assign shifted = {sif.shift_in, parallel_q[WIDTH-1:1]};
    end
  endgenerate

  // The window keeps sliding across word boundaries; only the counter wraps.
  always_comb begin
    parallel_d   = shifted;
    bit_count_d  = bit_count_q + CW'(1);
    word_valid_d = 1'b0;
    if (bit_count_q == LAST) begin
      bit_count_d  = '0;
      word_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parallel_q   <= '0;
      bit_count_q  <= '0;
      word_valid_q <= 1'b0;
    end else begin
      parallel_q   <= parallel_d;
      bit_count_q  <= bit_count_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign sif.parallel_out = parallel_q;
  assign sif.bit_count    = bit_count_q;
  assign sif.word_valid   = word_valid_q;

`ifdef SIPO_PARITY_EN
  logic parity_q, parity_d;

  // Parity tracks the value being loaded, so it lines up with parallel_out.
  always_comb begin
    parity_d = ^parallel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign sif.parity_out = parity_q;
`endif
endmodule

// File: tb/tb_sipo_shift_register.sv
// Directed bench: MSB-first instance for framing/reset cases, LSB-first instance for direction.
module tb_sipo_shift_register;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   failures;
  int   cycle;
  int   pulse1;
  int   pulse2;

  sipo_shift_register_if #(.WIDTH(4)) if_a ();
  sipo_shift_register_if #(.WIDTH(4)) if_b ();

  sipo_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst_a),
    .sif (if_a.slave)
  );

  sipo_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst_b),
    .sif (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive both serial inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic ba, input logic bb);
    if_a.shift_in = ba;
    if_b.shift_in = bb;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check_a(input string tag, input int po, input int bc, input int wv);
    check({tag, ".po"}, int'(if_a.parallel_out), po);
    check({tag, ".bc"}, int'(if_a.bit_count), bc);
    check({tag, ".wv"}, int'(if_a.word_valid), wv);
  endtask

  initial begin
    logic [3:0] bits2  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         exp2   [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    logic [3:0] bits3  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int         exp3   [4] = '{4'b0101, 4'b1011, 4'b0110, 4'b1101};
    int         expb   [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    checks   = 0;
    failures = 0;
    cycle    = 0;
    pulse1   = -1;
    pulse2   = -1;

    // Reset held two edges with shift_in=1: everything must stay zero.
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_a("rst", 4'b0000, 0, 0);
`ifdef SIPO_PARITY_EN
    check("rst.par", int'(if_a.parity_out), 0);
`endif

    // First word 1,0,1,0.
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(bits2[i][0], 1'b0);
      check_a($sformatf("w1[%0d]", i), exp2[i], (i + 1) % 4, (i == 3) ? 1 : 0);
      if (if_a.word_valid) pulse1 = cycle;
    end

    // Second word back-to-back 1,1,0,1.
    for (int i = 0; i < 4; i++) begin
      step(bits3[i][0], 1'b0);
      check_a($sformatf("w2[%0d]", i), exp3[i], (i + 1) % 4, (i == 3) ? 1 : 0);
      if (if_a.word_valid) pulse2 = cycle;
    end
    check("pulse_gap", pulse2 - pulse1, 4);

    // Two bits of a word, then reset discards them.
    step(1'b1, 1'b0);
    check_a("part[0]", 4'b1011, 1, 0);
    step(1'b1, 1'b0);
    check_a("part[1]", 4'b0111, 2, 0);
    rst_a = 1'b1;
    step(1'b1, 1'b0);
    check_a("midrst", 4'b0000, 0, 0);
    rst_a = 1'b0;
    step(1'b1, 1'b0);
    check_a("restart", 4'b0001, 1, 0);

    // Reset on the edge that would complete the word: no pulse.
    step(1'b0, 1'b0);
    check_a("rw[1]", 4'b0010, 2, 0);
    step(1'b1, 1'b0);
    check_a("rw[2]", 4'b0101, 3, 0);
    rst_a = 1'b1;
    step(1'b1, 1'b0);
    check_a("rstwins", 4'b0000, 0, 0);
    rst_a = 1'b0;

`ifdef SIPO_PARITY_EN
    // Parity of 0001,0011,0111,1110.
    begin
      int par_exp [4] = '{1, 0, 1, 1};
      int po_exp  [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110};
      logic [3:0] pb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        step(pb[i][0], 1'b0);
        check($sformatf("par[%0d].po", i), int'(if_a.parallel_out), po_exp[i]);
        check($sformatf("par[%0d]", i), int'(if_a.parity_out), par_exp[i]);
      end
    end
`endif

    // LSB-first instance from reset: 1,0,0,0.
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 0) ? 1'b1 : 1'b0);
      check($sformatf("lsb[%0d].po", i), int'(if_b.parallel_out), expb[i]);
      check($sformatf("lsb[%0d].wv", i), int'(if_b.word_valid), (i == 3) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
